// File: rtl/redmule_tcdm_responder.sv
// Wide-port TCDM responder: one DATA_W request per cycle against a 32-bit-word
// memory, with a fixed-latency response pipeline and read/write access counters.
module redmule_tcdm_responder #(
  parameter int unsigned DATA_W    = 288,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                stall_i,
  input  logic                tcdm_req_i,
  input  logic                tcdm_wen_i,
  input  logic [DATA_W/8-1:0] tcdm_be_i,
  input  logic [31:0]         tcdm_add_i,
  input  logic [DATA_W-1:0]   tcdm_data_i,
  input  logic                tcdm_user_i,
  output logic                tcdm_gnt_o,
  output logic                tcdm_r_valid_o,
  output logic [DATA_W-1:0]   tcdm_r_data_o,
  output logic                tcdm_r_opc_o,
  output logic                tcdm_r_user_o,
  output logic [31:0]         n_reads_o,
  output logic [31:0]         n_writes_o
);

  localparam int unsigned NLANE = DATA_W / 32;
  localparam int unsigned AW    = $clog2(MEM_WORDS);

  logic [31:0]       r_mem [MEM_WORDS];
  logic              r_pv  [LATENCY];
  logic [DATA_W-1:0] r_pd  [LATENCY];
  logic              r_po  [LATENCY];
  logic              r_pu  [LATENCY];
  logic [31:0]       r_nreads;
  logic [31:0]       r_nwrites;

  logic              w_txn;
  logic              w_misaligned;
  logic              w_wr;
  logic              w_rd;
  logic [AW-1:0]     w_base;
  logic [AW-1:0]     w_idx [NLANE];
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_new_data;
  logic              w_unused_addr;

  assign tcdm_gnt_o    = tcdm_req_i & ~stall_i;
  assign w_txn         = tcdm_req_i & ~stall_i;
  assign w_misaligned  = (tcdm_add_i[1:0] != 2'b00);
  assign w_wr          = w_txn & ~w_misaligned & ~tcdm_wen_i;
  assign w_rd          = w_txn & ~w_misaligned &  tcdm_wen_i;
  assign w_base        = tcdm_add_i[AW+1:2];
  assign w_unused_addr = ^tcdm_add_i[31:AW+2];

  // Lane indices wrap modulo MEM_WORDS through natural AW-bit truncation.
  always_comb begin
    for (int unsigned j = 0; j < NLANE; j++) begin
      w_idx[j]              = w_base + AW'(j);
      w_rdata[32*j +: 32]   = r_mem[w_idx[j]];
    end
  end

  assign w_new_data = w_rd ? w_rdata : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      for (int unsigned j = 0; j < NLANE; j++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (tcdm_be_i[4*j+b]) begin
            r_mem[w_idx[j]][8*b +: 8] <= tcdm_data_i[32*j+8*b +: 8];
          end
        end
      end
    end
  end

  // Non-valid stages carry zeros so the output fields are 0 whenever r_valid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_po[i] <= 1'b0;
        r_pu[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_txn;
      r_pd[0] <= w_new_data;
      r_po[0] <= w_txn & w_misaligned;
      r_pu[0] <= w_txn & tcdm_user_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_po[i] <= r_po[i-1];
        r_pu[i] <= r_pu[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_nreads  <= '0;
      r_nwrites <= '0;
    end else begin
      if (w_rd) r_nreads  <= r_nreads + 32'd1;
      if (w_wr) r_nwrites <= r_nwrites + 32'd1;
    end
  end

  assign tcdm_r_valid_o = r_pv[LATENCY-1];
  assign tcdm_r_data_o  = r_pd[LATENCY-1];
  assign tcdm_r_opc_o   = r_po[LATENCY-1];
  assign tcdm_r_user_o  = r_pu[LATENCY-1];
  assign n_reads_o      = r_nreads;
  assign n_writes_o     = r_nwrites;

endmodule

// File: doc/redmule_tcdm_responder.md
Name: redmule_tcdm_responder

Overview:
- Synthesizable wide-port TCDM responder: the memory-side end of the RedMulE wide data bus, with the request/response fields of redmule_default_data_req_t/rsp_t flattened to ports.
- Serves one 288-bit request per cycle from a 32-bit-word memory, returning responses after a fixed latency.
- Used as the L1 stand-in in RedMulE subsystem benches and FPGA smoke builds; exposes stall and access counters for test observability.

Parameters:
- DATA_W, 288, wide port width in bits; multiple of 32; NLANE = DATA_W/32 (9 at default).
- MEM_WORDS, 256, memory depth in 32-bit words; power of two.
- LATENCY, 2, grant-to-r_valid delay in cycles; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- stall_i  in  1  forces tcdm_gnt_o low (backpressure injection)
- tcdm_req_i  in  1  request
- tcdm_wen_i  in  1  1 = read, 0 = write
- tcdm_be_i  in  DATA_W/8  byte enables, writes only
- tcdm_add_i  in  32  byte address of lane 0
- tcdm_data_i  in  DATA_W  write data; lane j = bits [32j+31:32j]
- tcdm_user_i  in  1  user bit, echoed back
- tcdm_gnt_o  out  1  grant
- tcdm_r_valid_o  out  1  response valid
- tcdm_r_data_o  out  DATA_W  read data
- tcdm_r_opc_o  out  1  error flag (1 = misaligned)
- tcdm_r_user_o  out  1  echoed user bit
- n_reads_o  out  32  granted aligned reads
- n_writes_o  out  32  granted aligned writes

Behaviour:
- Reset:
  - All outputs 0; memory cleared to 0; response pipeline cleared.
  - Reset asserted mid-operation discards all in-flight responses; no r_valid until new requests are granted after release.
- Grant:
  - tcdm_gnt_o = tcdm_req_i & ~stall_i, combinational.
  - A transaction occurs only when req & gnt are both high.
- Lane addressing:
  - Word index for lane j = ((tcdm_add_i >> 2) + j) mod MEM_WORDS.
  - Index wraps at the top of memory, with no error.
- Misaligned request (tcdm_add_i[1:0] != 0):
  - Granted normally; memory untouched; counters unchanged.
  - Response carries r_opc=1 and r_data=0.
- Aligned write (granted, wen=0):
  - At the grant clock edge, byte b of lane j is updated iff tcdm_be_i[4j+b].
  - A response is still generated: r_valid=1, r_data=0, r_opc=0.
  - n_writes_o increments by 1.
- Aligned read (granted, wen=1):
  - All lanes are sampled at the grant edge; the value is the memory state after every earlier write.
  - A write granted in cycle T is visible to a read granted in T+1.
  - n_reads_o increments by 1.
- Response pipeline:
  - LATENCY-stage shift register of {valid, data, opc, user}.
  - A transaction granted in cycle T produces r_valid=1 exactly in cycle T+LATENCY, held for one cycle.
  - r_data/r_opc/r_user are valid only while r_valid=1 and are 0 otherwise.
  - There is no response backpressure; the requester must accept responses.
- Throughput: one transaction per cycle; back-to-back grants give back-to-back r_valid in order.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0.
- Simultaneous events:
  - stall_i high with req high: no grant, no side effects; the request must be held by the requester.
  - In-flight responses keep draining during stall.

Test Plan:
- Write/read-back, LATENCY=2: write add=0x0, lane j data = 0x10000000+j, be all ones in cycle T → r_valid in T+2 with r_data=0 and r_opc=0. Read add=0x0 granted in T+1 → r_valid in T+3 with lane j = 0x10000000+j. n_writes_o=1, n_reads_o=1.
- Byte enables: after the first test, write add=0x0, data all 0xFF, be with only bit 12 set (lane 3, byte 0) → readback lane 3 = 0x100000FF; all other lanes unchanged.
- Wrap: write add=0x3F8 (word 254), lane j = j → words 254, 255, 0 hold 0, 1, 2. Read add=0x0 → lane 0 = 2.
- Stall: req held high for 5 cycles with stall_i high in cycles 1-2 → gnt pattern 1,0,0,1,1; exactly 3 r_valid pulses, each LATENCY cycles after its grant.
- Misaligned: read at add=0x2 → gnt=1, r_opc=1, r_data=0 after LATENCY; n_reads_o unchanged; memory unchanged.
- Reset mid-flight: grant a read, then assert rst_ni low for 1 cycle before T+LATENCY → no r_valid appears; outputs and counters are 0; a subsequent read of any address returns 0.
